// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type and the default memory depth.
package lsu_pkg;

    localparam int unsigned DEF_MEM_WORDS = 64;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4,
        ERR   = 3'd5
    } lsu_state_e;

    // Access faults: illegal size, misalignment, or beyond the last byte.
    function automatic logic access_bad(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic bad;
        bad = (size == SZ_ILLEGAL) || (addr >= limit);
        if (size == SZ_HALF && addr[0]) bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus word-memory port of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Pipeline/memory environment side.
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_write, mem_address, mem_write_data
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: little-endian load extraction/extension and
// read-modify-write merging of byte/half store data into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data_c,
    output logic [31:0] merged_c
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        shamt   = 5'({offset, 3'b000});
        shifted = rdata >> shamt;
        case (size)
            SZ_BYTE: begin
                load_data_c = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                lane        = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_data_c = {{16{is_signed & shifted[15]}}, shifted[15:0]};
                lane        = 32'h0000_FFFF;
            end
            default: begin
                load_data_c = rdata;
                lane        = 32'hFFFF_FFFF;
            end
        endcase
        mask     = lane << shamt;
        merged_c = (rdata & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: validates an access, then performs a load, a
// direct word store, or a read-modify-write sub-word store to word memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);

    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    lsu_state_e  state, next_state;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        mem_write_q,  mem_write_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept_c;
    logic [31:0] addr_src_c;
    logic [31:0] load_data_c;
    logic [31:0] merged_c;

    assign accept_c   = (state == IDLE) && bus.req_valid;
    assign addr_src_c = accept_c ? bus.req_addr : lat_addr;

    lsu_lane_align u_align (
        .size        (lat_size),
        .offset      (lat_addr[1:0]),
        .is_signed   (lat_signed),
        .rdata       (bus.mem_read_data),
        .wdata       (lat_wdata),
        .load_data_c (load_data_c),
        .merged_c    (merged_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        next_state   = state;
        mem_wdata_d  = mem_wdata_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (access_bad(bus.req_size, bus.req_addr, MEM_BYTES)) next_state = ERR;
                    else if (!bus.req_write)                              next_state = LOAD;
                    else if (bus.req_size == SZ_WORD)                     next_state = WRITE;
                    else                                                  next_state = MERGE;
                end
            end
            LOAD:    next_state = RESP;
            MERGE:   next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (accept_c)        mem_wdata_d = bus.req_wdata;
        if (state == MERGE)  mem_wdata_d = merged_c;

        mem_write_d  = (next_state == WRITE);
        mem_addr_d   = (next_state == LOAD || next_state == MERGE || next_state == WRITE)
                     ? {addr_src_c[31:2], 2'b00} : 32'h0;
        resp_valid_d = (next_state == RESP) || (next_state == ERR);
        resp_error_d = (next_state == ERR);
        resp_rdata_d = (state == LOAD && !lat_write) ? load_data_c : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_signed   <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state        <= next_state;
            if (accept_c) begin
                lat_write  <= bus.req_write;
                lat_size   <= bus.req_size;
                lat_signed <= bus.req_signed;
                lat_addr   <= bus.req_addr;
                lat_wdata  <= bus.req_wdata;
            end
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Reset in the WRITE cycle must kill the strobe before the memory samples it.
    assign bus.mem_write      = mem_write_q & ~reset;
    assign bus.req_ready      = (state == IDLE);
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-level memory
// model that tracks expected contents, load values and response timing.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned MW = 64;

    logic clk = 1'b0;
    logic reset;
    logic mem_load;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mem_read_data = (bus.mem_address[31:2] < 30'(MW)) ? mem[bus.mem_address[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MW; i++) mem[i] <= (i == 4) ? 32'h8899AABB : 32'(i);
        end else if (bus.mem_write && bus.mem_address[31:2] < 30'(MW)) begin
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_error(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz == 2'b11) return 1'b1;
        nbytes = 1 << sz;
        if ((a % nbytes) != 0) return 1'b1;
        return a >= 32'(4 * MW);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] v;
        longint      val;
        int          nbytes;
        nbytes = 1 << sz;
        v      = ref_mem[a / 4];
        val    = 0;
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b   = 8'(v >> (8 * ((a % 4) + i)));
            val = val + longint'(b) * (longint'(1) << (8 * i));
        end
        if (sg && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
            val = val - (longint'(1) << (8 * nbytes));
        return 32'(val);
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nbytes;
        int w;
        int off;
        nbytes = 1 << sz;
        w      = int'(a / 4);
        off    = int'(a % 4);
        for (int i = 0; i < nbytes; i++) ref_mem[w][8 * (off + i) +: 8] = wd[8 * i +: 8];
    endfunction

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    // One complete access, checked for latency, data, error flag and memory writes.
    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got_rd);
        logic        err;
        int          lat, resp_at, nresp, nwr, wr_at, g;
        logic [31:0] exp_rd, exp_word, wr_data, wr_addr, got_err;
        int          widx;
        err      = model_error(sz, a);
        widx     = int'(a / 4);
        exp_rd   = 32'h0;
        exp_word = 32'h0;
        if (!err && !w) exp_rd = model_load(sz, sg, a);
        if (!err && w) begin
            model_store(sz, a, wd);
            exp_word = ref_mem[widx];
        end
        lat = err ? 1 : ((!w || sz == SZ_WORD) ? 2 : 3);

        g = 0;
        while (!bus.req_ready && g < 10) begin @(negedge clk); g++; end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
        drive_req(w, sz, sg, a, wd);
        resp_at = 0; nresp = 0; nwr = 0; wr_at = 0;
        wr_data = 32'h0; wr_addr = 32'h0; got_rd = 32'h0; got_err = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                nresp++;
                if (resp_at == 0) begin
                    resp_at = k;
                    got_rd  = bus.resp_rdata;
                    got_err = 32'(bus.resp_error);
                end
            end
            if (bus.mem_write) begin
                nwr++;
                wr_at   = k;
                wr_data = bus.mem_write_data;
                wr_addr = bus.mem_address;
            end
        end
        chk({tag, "_lat"}, 32'(resp_at), 32'(lat));
        chk({tag, "_nresp"}, 32'(nresp), 32'h1);
        chk({tag, "_err"}, got_err, 32'(err));
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_nwr"}, 32'(nwr), (w && !err) ? 32'h1 : 32'h0);
        if (w && !err) begin
            chk({tag, "_wr_at"}, 32'(wr_at), 32'(lat - 1));
            chk({tag, "_wr_data"}, wr_data, exp_word);
            chk({tag, "_wr_addr"}, wr_addr, 32'(widx * 4));
        end
    endtask

    initial begin
        logic [31:0] rd, ea, eb;
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, ea, eb;
        reset    = 1'b1;
        mem_load = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < MW; i++) ref_mem[i] = (i == 4) ? 32'h8899AABB : 32'(i);
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        mem_load = 1'b0;
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
        chk("rst_mem_addr", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'h0);

        access("lb_s", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, rd);
        chk("lb_s_const", rd, 32'hFFFFFFAA);
        access("lb_u", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, rd);
        chk("lb_u_const", rd, 32'h000000AA);

        access("sh", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, rd);
        chk("sh_mem_const", mem[4], 32'h1234AABB);
        access("sh_rb", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
        chk("sh_rb_const", rd, 32'h1234AABB);

        access("lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, rd);
        access("sw_oor", 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hCAFEF00D, rd);
        access("ill_sz", 1'b1, SZ_ILLEGAL, 1'b0, 32'h20, 32'h12345678, rd);

        access("sw_top", 1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hDEADBEEF, rd);
        access("lw_top", 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, rd);
        chk("lw_top_const", rd, 32'hDEADBEEF);

        // Reset during the WRITE cycle of a byte store: nothing may reach memory.
        drive_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000005A);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_strobe_before", 32'(bus.mem_write), 32'h1);
        reset = 1'b1;
        #1;
        chk("rstw_gated", 32'(bus.mem_write), 32'h0);
        @(negedge clk);
        chk("rstw_resp", 32'(bus.resp_valid), 32'h0);
        chk("rstw_ready", 32'(bus.req_ready), 32'h1);
        reset = 1'b0;
        chk("rstw_mem", mem[8], ref_mem[8]);
        chk("rstw_mem_const", mem[8], 32'h00000008);

        // Back-to-back loads with req_valid held high.
        ea = model_load(SZ_WORD, 1'b0, 32'h10);
        eb = model_load(SZ_HALF, 1'b1, 32'h1E);
        drive_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        chk("b2b_ready_n", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        chk("b2b_ready_n1", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        chk("b2b_ready_n2", 32'(bus.req_ready), 32'h0);
        chk("b2b_resp_a", 32'(bus.resp_valid), 32'h1);
        chk("b2b_rdata_a", bus.resp_rdata, ea);
        drive_req(1'b0, SZ_HALF, 1'b1, 32'h1E, 32'h0);
        @(negedge clk);
        chk("b2b_ready_n3", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_ready_n4", 32'(bus.req_ready), 32'h0);
        chk("b2b_noresp_n4", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        chk("b2b_resp_b", 32'(bus.resp_valid), 32'h1);
        chk("b2b_rdata_b", bus.resp_rdata, eb);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            logic        w, sg;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
            wd = $urandom;
            access($sformatf("rnd%0d", n), w, sz, sg, a, wd, rd);
        end

        for (int i = 0; i < MW; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 64, number of 32-bit words behind the memory port; legal byte addresses are 0 .. 4*MEM_WORDS-1.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline M-stage access request.
REQ-005 req_ready  out  1  unit can accept a request this cycle; a request is accepted when req_valid && req_ready.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-008 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle pulse when the accepted access completes.
REQ-012 resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_error  out  1  valid with resp_valid: misaligned, out-of-range or illegal size.
REQ-014 mem_write  out  1  write strobe to the word memory.
REQ-015 mem_address  out  32  word-aligned byte address to memory (bits [1:0] = 00).
REQ-016 mem_write_data  out  32  full word to write.
REQ-017 mem_read_data  in  32  combinational read data for mem_address.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, MERGE, WRITE, RESP, ERR.
REQ-019 The unit SHALL assert req_ready only in IDLE and SHALL latch req_* on acceptance.
REQ-020 On acceptance, the unit SHALL go to ERR if the access is misaligned (half: addr[0]=1; word: addr[1:0]!=0), size=11, or addr >= 4*MEM_WORDS.
REQ-021 Otherwise: loads go to LOAD, word stores to WRITE, byte/half stores to MERGE.
REQ-022 In LOAD, the unit SHALL drive mem_address and register the little-endian lane selected by addr[1:0], extended per req_signed, then go to RESP.
REQ-023 In MERGE, the unit SHALL read the word, replace only the addressed byte/half lanes with req_wdata[7:0]/[15:0], register the merged word, then go to WRITE.
REQ-024 In WRITE, the unit SHALL assert mem_write for exactly one cycle with the merged or store word, then go to RESP.
REQ-025 RESP and ERR SHALL each last one cycle with resp_valid=1 (resp_error=1 only in ERR), then return to IDLE.
REQ-026 Latency from the acceptance cycle N SHALL be: error N+1; load and word store N+2; sub-word store N+3.
REQ-027 mem_write SHALL be 0 in every state except WRITE; an erroring access SHALL never write memory.
REQ-028 mem_address SHALL be {latched_addr[31:2],2'b00} in LOAD/MERGE/WRITE and 0 otherwise.
REQ-029 req_valid while req_ready=0 SHALL be ignored; the requester holds the request.

Reset
REQ-030 When reset=1 at a clock edge, the state SHALL become IDLE and all registered outputs/data SHALL clear to 0; after reset, req_ready=1.
REQ-031 mem_write SHALL be gated by !reset, so that a reset asserted during WRITE suppresses that write.
REQ-032 An access interrupted by reset SHALL produce no resp_valid.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the default MEM_WORDS.
REQ-034 A purely combinational sub-module, lsu_lane_align, SHALL perform load extraction/extension and store lane merging; the FSM and registers stay in load_store_unit.

Verification (memory model word 0x10 = 0x8899AABB; others = index)
REQ-035 Load byte, addr 0x11, signed -> resp_valid at N+2, resp_rdata 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-036 Store half 0x1234 at 0x12 -> MERGE then one mem_write at N+2 with 0x1234AABB; resp_valid at N+3; word 0x10 reads back 0x1234AABB.
REQ-037 Load word at 0x102 -> resp_valid with resp_error at N+1, resp_rdata 0, no memory access; store word at 0x100 (MEM_WORDS=64) -> error, mem_write never asserted.
REQ-038 Word store 0xDEADBEEF to 0xFC -> mem_write at N+1, resp_valid at N+2; then load word 0xFC -> 0xDEADBEEF.
REQ-039 Reset asserted in the WRITE cycle of a byte store -> no mem_write, no resp_valid, req_ready=1 next cycle, memory unchanged.
REQ-040 req_valid held high for back-to-back loads -> second request accepted only in the cycle after RESP, with req_ready=0 in between.
